// File: rtl/axi_slave_pkg.sv
// Shared constants for the AXI4-subset SRAM slave: FSM encoding, response codes, widths.
package axi_slave_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned ST_W   = 3;

  // FSM encoding, kept as plain constants for legacy tools
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_RD_FETCH = 3'd1;
  localparam logic [ST_W-1:0] ST_RD_DATA  = 3'd2;
  localparam logic [ST_W-1:0] ST_WR_DATA  = 3'd3;
  localparam logic [ST_W-1:0] ST_WR_RESP  = 3'd4;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  // Byte increment between beats; sizes wider than the 32-bit bus act as a full word
  function automatic logic [ADDR_W-1:0] beat_incr(input logic [SIZE_W-1:0] size);
    logic [ADDR_W-1:0] incr;
    incr = 32'd4;
    if (size < 3'd2) begin
      incr = ADDR_W'(1) << size;
    end
    return incr;
  endfunction

endpackage

// File: rtl/axi_sram_slave_mem.sv
// 1R1W synchronous RAM with a registered read port; only the read register is reset.
module axi_sram_slave_mem #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          rclr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Write port: array contents are never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: registered, forced to zero on reset or for a cleared (out-of-range) read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rclr ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-subset (INCR, 32-bit, no WSTRB/ID/RRESP) slave backed by on-chip SRAM.
// One burst in flight; round-robin AR/AW arbitration in IDLE.
// Optional range checking / SLVERR reporting: define AXI_SRAM_SLAVE_ERR_EN.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int unsigned MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [SIZE_W-1:0] ARSIZE,
  output logic              RVALID,
  output logic [DATA_W-1:0] RDATA,
  input  logic              RREADY,
  output logic              RLAST,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [SIZE_W-1:0] AWSIZE,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [RESP_W-1:0] BRESP
);

  logic [ST_W-1:0]   state_q, state_d;
  logic              ptr_rd_q, ptr_rd_d;
  logic              arready_q, arready_d;
  logic              awready_q, awready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [RESP_W-1:0] bresp_q, bresp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              err_q, err_d;

  logic [MEM_AW-1:0] word_c;
  logic              oor_c;
  logic              mem_we_c;
  logic              mem_re_c;

  // Word index of the current beat; wraps modulo memory depth
  assign word_c = MEM_AW'((addr_q - BASE_ADDR) >> 2);

  // Out-of-range detection for the current beat
`ifdef AXI_SRAM_SLAVE_ERR_EN
  assign oor_c = (addr_q < BASE_ADDR) ||
                 (((addr_q - BASE_ADDR) >> (MEM_AW + 2)) != '0);
`else
  assign oor_c = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    ptr_rd_d  = ptr_rd_q;
    arready_d = 1'b0;
    awready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    err_d     = err_q;
    mem_we_c  = 1'b0;
    mem_re_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arready_q && ARVALID) begin
          addr_d  = ARADDR;
          len_d   = ARLEN;
          size_d  = ARSIZE;
          cnt_d   = '0;
          state_d = ST_RD_FETCH;
        end else if (awready_q && AWVALID) begin
          addr_d   = AWADDR;
          len_d    = AWLEN;
          size_d   = AWSIZE;
          cnt_d    = '0;
          ovr_d    = 1'b0;
          err_d    = 1'b0;
          wready_d = 1'b1;
          state_d  = ST_WR_DATA;
        end else if (!arready_q && !awready_q) begin
          // Pointer at "read" means the write channel wins a contested grant
          if (AWVALID && (!ARVALID || ptr_rd_q)) begin
            awready_d = 1'b1;
            ptr_rd_d  = !ptr_rd_q;
          end else if (ARVALID) begin
            arready_d = 1'b1;
            ptr_rd_d  = !ptr_rd_q;
          end
        end
      end

      ST_RD_FETCH: begin
        mem_re_c = 1'b1;
        rvalid_d = 1'b1;
        rlast_d  = (cnt_q == len_q);
        state_d  = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = addr_q + beat_incr(size_q);
            state_d = ST_RD_FETCH;
          end
        end
      end

      ST_WR_DATA: begin
        if (WVALID && wready_q) begin
          // Beats past the announced length are accepted but dropped
          mem_we_c = !ovr_q && !oor_c;
          if (!ovr_q && oor_c) begin
            err_d = 1'b1;
          end
          if (WLAST) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
`ifdef AXI_SRAM_SLAVE_ERR_EN
            bresp_d  = (err_q || (oor_c && !ovr_q) || ovr_q || (cnt_q != len_q)) ?
                       RESP_SLVERR : RESP_OKAY;
`else
            bresp_d  = RESP_OKAY;
`endif
            state_d  = ST_WR_RESP;
          end else if (cnt_q == len_q) begin
            ovr_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = addr_q + beat_incr(size_q);
          end
        end
      end

      ST_WR_RESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_rd_q  <= 1'b1;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_rd_q  <= ptr_rd_d;
      arready_q <= arready_d;
      awready_q <= awready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
    end
  end

  assign ARREADY = arready_q;
  assign AWREADY = awready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

  axi_sram_slave_mem #(
    .AW (MEM_AW),
    .DW (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_c),
    .waddr (word_c),
    .wdata (WDATA),
    .re    (mem_re_c),
    .raddr (word_c),
    .rclr  (oor_c),
    .rdata (RDATA)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus randomized bursts
// compared against a word-array reference memory.
module tb_axi_sram_slave;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int S_AR = 0, S_AW = 1, S_W = 2, S_R = 3, S_B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  BRESP;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_vld [DEPTH];
  bit          ptr_rd_m;

  axi_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .RVALID(RVALID), .RDATA(RDATA), .RREADY(RREADY), .RLAST(RLAST),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] incr(input logic [2:0] s);
    return (s > 3'd2) ? 32'd4 : (32'd1 << s);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
  endfunction

  function automatic bit oor(input logic [31:0] a);
`ifdef AXI_SRAM_SLAVE_ERR_EN
    return (a < BASE) || (((a - BASE) >> 2) >= 32'(DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      S_AR:    return ARREADY;
      S_AW:    return AWREADY;
      S_W:     return WREADY;
      S_R:     return RVALID;
      S_B:     return BVALID;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int sel, input string tag);
    int n;
    n = 0;
    while (sig(sel) !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(sig(sel)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ARVALID = 0; AWVALID = 0; WVALID = 0; WLAST = 0; RREADY = 0; BREADY = 0;
    ARADDR = 0; AWADDR = 0; ARLEN = 0; AWLEN = 0; ARSIZE = 0; AWSIZE = 0; WDATA = 0;
    tick();
    tick();
    rst = 1'b1;
    ptr_rd_m = 1'b1;
    tick();
  endtask

  task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size);
    AWADDR = a; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
    wait_for(S_AW, "awready");
    tick();
    AWVALID = 1'b0;
    ptr_rd_m = !ptr_rd_m;
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size);
    ARADDR = a; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
    wait_for(S_AR, "arready");
    tick();
    ARVALID = 1'b0;
    ptr_rd_m = !ptr_rd_m;
  endtask

  task automatic w_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input int nbeats, input bit seq, output logic [1:0] exp_bresp);
    bit          bad;
    logic [31:0] ba, d;
    int          gap;
    bad = (nbeats != int'(len) + 1);
    for (int k = 0; k < nbeats; k++) begin
      gap = seq ? 0 : int'($urandom_range(0, 2));
      WVALID = 1'b0;
      repeat (gap) tick();
      d = seq ? 32'(k + 1) : $urandom;
      WDATA = d; WLAST = (k == nbeats - 1); WVALID = 1'b1;
      wait_for(S_W, "wready");
      tick();
      if (k <= int'(len)) begin
        ba = a + 32'(k) * incr(size);
        if (oor(ba)) begin
          bad = 1'b1;
        end else begin
          ref_mem[widx(ba)] = d;
          ref_vld[widx(ba)] = 1'b1;
        end
      end
    end
    WVALID = 1'b0; WLAST = 1'b0;
`ifdef AXI_SRAM_SLAVE_ERR_EN
    exp_bresp = bad ? 2'b10 : 2'b00;
`else
    exp_bresp = 2'b00;
`endif
  endtask

  task automatic b_phase(input logic [1:0] exp_bresp);
    BREADY = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    wait_for(S_B, "bvalid");
    chk("bresp", 32'(BRESP), 32'(exp_bresp));
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bvalid_drop", 32'(BVALID), 32'd0);
  endtask

  task automatic r_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input int stall_beat, input int stall_n);
    logic [31:0] ba, snap;
    logic        sl;
    int          n;
    for (int k = 0; k <= int'(len); k++) begin
      wait_for(S_R, "rvalid");
      ba = a + 32'(k) * incr(size);
      if (oor(ba)) chk("rdata_oor", RDATA, 32'd0);
      else if (ref_vld[widx(ba)]) chk("rdata", RDATA, ref_mem[widx(ba)]);
      chk("rlast", 32'(RLAST), 32'(k == int'(len)));
      snap = RDATA; sl = RLAST;
      n = (k == stall_beat) ? stall_n : int'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        tick();
        chk("hold_rvalid", 32'(RVALID), 32'd1);
        chk("hold_rdata", RDATA, snap);
        chk("hold_rlast", 32'(RLAST), 32'(sl));
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      chk("rvalid_drop", 32'(RVALID), 32'd0);
    end
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                             input int nbeats, input bit seq);
    logic [1:0] e;
    aw_phase(a, len, size);
    w_phase(a, len, size, nbeats, seq, e);
    b_phase(e);
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input int stall_beat, input int stall_n);
    ar_phase(a, len, size);
    r_phase(a, len, size, stall_beat, stall_n);
  endtask

  initial begin
    logic [1:0]  e;
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    int          nb, sel, n;

    // Reset values
    rst = 1'b0;
    ARVALID = 0; AWVALID = 0; WVALID = 0; WLAST = 0; RREADY = 0; BREADY = 0;
    ARADDR = 0; AWADDR = 0; ARLEN = 0; AWLEN = 0; ARSIZE = 0; AWSIZE = 0; WDATA = 0;
    ptr_rd_m = 1'b1;
    tick();
    tick();
    chk("rst_ctl", 32'({ARREADY, AWREADY, RVALID, RLAST, WREADY, BVALID, BRESP}), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_ctl", 32'({ARREADY, AWREADY, RVALID, RLAST, WREADY, BVALID, BRESP}), 32'd0);

    // Write 1..4 at 0x10, read back
    write_burst(32'h10, 8'd3, 3'd2, 4, 1'b1);
    read_burst(32'h10, 8'd3, 3'd2, -1, 0);

    // Back-pressure on beat 2
    read_burst(32'h10, 8'd3, 3'd2, 1, 5);

    // Contested arbitration from a fresh reset
    do_reset();
    AWADDR = 32'h80; AWLEN = 8'd1; AWSIZE = 3'd2;
    ARADDR = 32'h80; ARLEN = 8'd1; ARSIZE = 3'd2;
    AWVALID = 1'b1; ARVALID = 1'b1;
    n = 0;
    while (!(AWREADY || ARREADY) && n < 50) begin tick(); n++; end
    chk("arb1_awready", 32'(AWREADY), 32'(ptr_rd_m));
    chk("arb1_arready", 32'(ARREADY), 32'(!ptr_rd_m));
    tick();
    AWVALID = 1'b0;
    ptr_rd_m = !ptr_rd_m;
    w_phase(32'h80, 8'd1, 3'd2, 2, 1'b0, e);
    chk("ar_wait_low", 32'(ARREADY), 32'd0);
    b_phase(e);
    AWADDR = 32'hA0; AWLEN = 8'd0; AWSIZE = 3'd2; AWVALID = 1'b1;
    n = 0;
    while (!(AWREADY || ARREADY) && n < 50) begin tick(); n++; end
    chk("arb2_awready", 32'(AWREADY), 32'(ptr_rd_m));
    chk("arb2_arready", 32'(ARREADY), 32'(!ptr_rd_m));
    tick();
    ARVALID = 1'b0;
    ptr_rd_m = !ptr_rd_m;
    r_phase(32'h80, 8'd1, 3'd2, -1, 0);
    wait_for(S_AW, "aw_after_read");
    tick();
    AWVALID = 1'b0;
    ptr_rd_m = !ptr_rd_m;
    w_phase(32'hA0, 8'd0, 3'd2, 1, 1'b0, e);
    b_phase(e);
    read_burst(32'hA0, 8'd0, 3'd2, -1, 0);

    // Top word of memory
    write_burst(32'hFFC, 8'd0, 3'd2, 1, 1'b0);
    read_burst(32'hFFC, 8'd0, 3'd2, -1, 0);

    // Length overrun: third beat must not land in memory
    write_burst(32'h48, 8'd0, 3'd2, 1, 1'b0);
    write_burst(32'h40, 8'd1, 3'd2, 3, 1'b0);
    read_burst(32'h40, 8'd2, 3'd2, -1, 0);

    // Randomized bursts
    for (int it = 0; it < 30; it++) begin
      ra = 32'($urandom_range(0, 32'h17FF));
      rl = 8'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 5));
      nb = (sel == 0 && rl != 0) ? int'(rl) : (sel == 1) ? int'(rl) + 2 : int'(rl) + 1;
      write_burst(ra, rl, rs, nb, 1'b0);
      read_burst(ra, rl, rs, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    // Reset pulse in the middle of a read burst
    write_burst(32'h10, 8'd3, 3'd2, 4, 1'b1);
    ar_phase(32'h10, 8'd3, 3'd2);
    wait_for(S_R, "mid_rvalid");
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    wait_for(S_R, "mid_rvalid2");
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_ctl", 32'({ARREADY, AWREADY, RVALID, RLAST, WREADY, BVALID, BRESP}), 32'd0);
    chk("async_rst_rdata", RDATA, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ptr_rd_m = 1'b1;
    tick();
    read_burst(32'h10, 8'd3, 3'd2, -1, 0);
    write_burst(32'h20, 8'd1, 3'd2, 2, 1'b0);
    read_burst(32'h20, 8'd1, 3'd2, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
